// File: rtl/seg_scan_pkg.sv
// Shared types and default sizing for the multiplexed segment display scanner.
package seg_scan_pkg;

  // Per-cycle scan phase: IDLE while disabled, ON while the digit is lit,
  // OFF for the dark remainder of a slot.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam int DEF_DIGITS = 10;
  localparam int DEF_SEG_W  = 8;
  localparam int DEF_DIV_W  = 16;

endpackage

// File: rtl/seg_slot_timer.sv
// Slot timer: counts cycles inside one digit slot, latches the slot/on-time
// configuration at slot boundaries and tells the scanner whether the next
// cycle falls inside the lit window.
module seg_slot_timer
  import seg_scan_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,        // scan enable
  input  logic             run_i,       // scanner is already past IDLE
  input  logic [DIV_W-1:0] cfg_div_i,   // slot length minus one
  input  logic [DIV_W-1:0] cfg_on_i,    // lit cycles per slot
  output logic             slot_end_o,  // current cycle is the last of its slot
  output logic             on_phase_o   // cycle after the coming edge is lit
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] slot_len_q;
  logic [DIV_W-1:0] on_len_q;
  logic [DIV_W:0]   cnt_inc_s;
  logic             start_s;
  logic             reload_s;

  // Slot boundary detection and look-ahead of the lit window.
  always_comb begin
    start_s    = en_i & ~run_i;
    slot_end_o = en_i & run_i & (cnt_q == slot_len_q);
    reload_s   = start_s | slot_end_o;
    cnt_inc_s  = {1'b0, cnt_q} + (DIV_W + 1)'(1);
    if (reload_s) begin
      // A fresh slot starts at count 0, lit only if the new on-time is non-zero.
      on_phase_o = (cfg_on_i != {DIV_W{1'b0}});
    end else begin
      on_phase_o = (cnt_inc_s < {1'b0, on_len_q});
    end
  end

  // Slot counter and configuration latch; cfg is only sampled at slot start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= {DIV_W{1'b0}};
      slot_len_q <= {DIV_W{1'b0}};
      on_len_q   <= {DIV_W{1'b0}};
    end else if (!en_i) begin
      cnt_q <= {DIV_W{1'b0}};
    end else if (reload_s) begin
      cnt_q      <= {DIV_W{1'b0}};
      slot_len_q <= cfg_div_i;
      on_len_q   <= cfg_on_i;
    end else begin
      cnt_q <= cnt_inc_s[DIV_W-1:0];
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed segment display scanner with double-buffered digit patterns.
// Patterns are written into a shadow buffer and copied to the displayed
// (active) buffer only at a frame boundary, or at once while idle.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int SEG_W  = DEF_SEG_W,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int AW     = $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_on,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [AW-1:0]     wr_addr,
  input  logic [SEG_W-1:0]  wr_data,
  input  logic              commit,
  output logic [SEG_W-1:0]  segm,
  output logic [DIGITS-1:0] sel,
  output logic              frame_tick
);

  localparam int                IW       = $clog2(DIGITS);
  localparam logic [IW-1:0]     LAST_IDX = IW'(DIGITS - 1);
  localparam logic [AW:0]       DIGITS_W = (AW + 1)'(DIGITS);
  localparam logic [DIGITS-1:0] SEL_ONE  = {{(DIGITS - 1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     idx_d;
  logic [SEG_W-1:0]  shadow_q [DIGITS];
  logic [SEG_W-1:0]  active_q [DIGITS];
  logic              commit_pending_q;
  logic [DIGITS-1:0] sel_q;
  logic [SEG_W-1:0]  segm_q;

  logic              run_s;
  logic              slot_end_s;
  logic              on_phase_s;
  logic              frame_end_s;
  logic              wr_en_s;
  logic              apply_s;

  assign run_s = (state_q != ST_IDLE);

  seg_slot_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (cfg_en),
    .run_i      (run_s),
    .cfg_div_i  (cfg_div),
    .cfg_on_i   (cfg_on),
    .slot_end_o (slot_end_s),
    .on_phase_o (on_phase_s)
  );

  // Frame end, write acceptance, commit application and next digit index.
  always_comb begin
    frame_end_s = slot_end_s & (idx_q == LAST_IDX);
    wr_en_s     = wr_valid & ~commit_pending_q & ({1'b0, wr_addr} < DIGITS_W);
    // While idle there is no frame to tear, so a pending copy goes through.
    apply_s     = commit_pending_q & (frame_end_s | ~run_s);
    if (!cfg_en || !run_s) begin
      idx_d = {IW{1'b0}};
    end else if (slot_end_s) begin
      if (idx_q == LAST_IDX) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Scan FSM with registered digit select and segment drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= {IW{1'b0}};
      sel_q   <= {DIGITS{1'b0}};
      segm_q  <= {SEG_W{1'b0}};
    end else begin
      case (state_q)
        ST_ON: begin
          // Blank on the same edge that drops to IDLE so sel never lingers.
          if (cfg_en) begin
            sel_q  <= SEL_ONE << idx_q;
            segm_q <= active_q[idx_q];
          end else begin
            sel_q  <= {DIGITS{1'b0}};
            segm_q <= {SEG_W{1'b0}};
          end
        end
        default: begin
          sel_q  <= {DIGITS{1'b0}};
          segm_q <= {SEG_W{1'b0}};
        end
      endcase
      if (!cfg_en) begin
        state_q <= ST_IDLE;
      end else if (on_phase_s) begin
        state_q <= ST_ON;
      end else begin
        state_q <= ST_OFF;
      end
      idx_q <= idx_d;
    end
  end

  // Shadow/active pattern buffers and the pending-commit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        shadow_q[i] <= {SEG_W{1'b0}};
        active_q[i] <= {SEG_W{1'b0}};
      end
      commit_pending_q <= 1'b0;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_en_s && (wr_addr == AW'(i))) begin
          shadow_q[i] <= wr_data;
        end
        if (apply_s) begin
          active_q[i] <= shadow_q[i];
        end
      end
      // A commit landing on the applying edge survives until the next boundary.
      commit_pending_q <= commit | (commit_pending_q & ~apply_s);
    end
  end

  assign wr_ready   = ~commit_pending_q;
  assign frame_tick = frame_end_s;
  assign sel        = sel_q;
  assign segm       = segm_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 3-bit write address so
// out-of-range addresses can be exercised).
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int SEG_W  = 8;
  localparam int DIV_W  = 16;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_en;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  cfg_on;
  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr;
  logic [SEG_W-1:0]  wr_data;
  logic              commit;
  logic [SEG_W-1:0]  segm;
  logic [DIGITS-1:0] sel;
  logic              frame_tick;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: slot position, slot/on lengths in cycles, digit,
  // both pattern buffers and the pending flag, plus expected registered outputs.
  bit               m_run;
  int               m_pos, m_len, m_on, m_dig;
  logic [SEG_W-1:0] m_sh [DIGITS];
  logic [SEG_W-1:0] m_ac [DIGITS];
  bit               m_pend;
  logic [DIGITS-1:0] m_sel;
  logic [SEG_W-1:0] m_segm;
  bit               last_ft;
  logic [DIGITS-1:0] last_sel;

  typedef struct {
    int div;
    int on;
    int exp_period;
    int exp_lit;
  } vec_t;
  vec_t vecs [7];

  seg_scan_ctrl #(
    .DIGITS (DIGITS),
    .SEG_W  (SEG_W),
    .DIV_W  (DIV_W),
    .AW     (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_en     (cfg_en),
    .cfg_div    (cfg_div),
    .cfg_on     (cfg_on),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .segm       (segm),
    .sel        (sel),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pos = 0; m_len = 1; m_on = 0; m_dig = 0; m_pend = 1'b0;
    m_sel = '0; m_segm = '0;
    for (int i = 0; i < DIGITS; i++) begin
      m_sh[i] = '0;
      m_ac[i] = '0;
    end
  endtask

  // One clock: check pre-edge outputs, advance the model, check post-edge outputs.
  task automatic step();
    bit ft, lit, apply, we, en, cm;
    int na, dv, on;
    logic [SEG_W-1:0] wd;
    @(negedge clk);
    en = cfg_en; cm = commit; we = wr_valid; na = int'(wr_addr); wd = wr_data;
    dv = int'(cfg_div); on = int'(cfg_on);
    ft = m_run && en && (m_pos == m_len - 1) && (m_dig == DIGITS - 1);
    chk("frame_tick", frame_tick, ft);
    chk("wr_ready", wr_ready, !m_pend);
    last_ft = frame_tick;
    lit = m_run && en && (m_pos < m_on);
    @(posedge clk);
    m_sel  = lit ? (DIGITS'(1) << m_dig) : '0;
    m_segm = lit ? m_ac[m_dig] : '0;
    if (we && !m_pend && na < DIGITS) m_sh[na] = wd;
    apply = m_pend && (ft || !m_run);
    if (apply) for (int i = 0; i < DIGITS; i++) m_ac[i] = m_sh[i];
    m_pend = cm || (m_pend && !apply);
    if (!en) begin
      m_run = 1'b0; m_pos = 0; m_dig = 0;
    end else if (!m_run || m_pos == m_len - 1) begin
      m_dig = m_run ? (m_dig + 1) % DIGITS : 0;
      m_run = 1'b1; m_pos = 0; m_len = dv + 1; m_on = on;
    end else begin
      m_pos++;
    end
    #1;
    chk("sel", sel, m_sel);
    chk("segm", segm, m_segm);
    chk("sel_onehot", ($countones(sel) <= 1), 1);
    last_sel = sel;
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin step(); n++; end while (!last_ft && n < 300);
    chk("tick_seen", last_ft, 1'b1);
  endtask

  task automatic run_cfg(input int div, input int on, output int period, output int lit2);
    cfg_en = 1'b0; step(); step();
    cfg_div = DIV_W'(div); cfg_on = DIV_W'(on); cfg_en = 1'b1;
    wait_tick();
    period = 0; lit2 = 0;
    do begin
      step(); period++;
      if (last_sel == 4'b0100) lit2++;
    end while (!last_ft && period < 300);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_sel", sel, 0); chk("rst_segm", segm, 0);
    chk("rst_ft", frame_tick, 0); chk("rst_wr_ready", wr_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int period, lit2, c0, c1, n;
    vecs[0] = '{3, 4, 16, 4};
    vecs[1] = '{3, 2, 16, 2};
    vecs[2] = '{3, 0, 16, 0};
    vecs[3] = '{1, 1, 8, 1};
    vecs[4] = '{0, 5, 4, 1};
    vecs[5] = '{7, 3, 32, 3};
    vecs[6] = '{2, 9, 12, 3};

    cfg_en = 1'b0; cfg_div = '0; cfg_on = '0; wr_valid = 1'b0;
    wr_addr = '0; wr_data = '0; commit = 1'b0;
    do_reset();

    // Load all digits while idle; the commit applies without a frame.
    for (int i = 0; i < DIGITS; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = SEG_W'(8'h11 * (i + 1));
      step();
    end
    wr_valid = 1'b0; commit = 1'b1; step(); commit = 1'b0; step(); step();

    // Table-driven frame period and per-digit lit time.
    foreach (vecs[k]) begin
      run_cfg(vecs[k].div, vecs[k].on, period, lit2);
      chk($sformatf("period_v%0d", k), period, vecs[k].exp_period);
      chk($sformatf("lit_v%0d", k), lit2, vecs[k].exp_lit);
    end

    // Write + commit at frame cycle 5; shown only in the following frame.
    cfg_div = 16'd3; cfg_on = 16'd4; wait_tick();
    repeat (5) step();
    wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 8'h3F; step();
    wr_valid = 1'b0; commit = 1'b1; step(); commit = 1'b0;
    chk("wr_ready_low", wr_ready, 1'b0);
    wait_tick();
    repeat (DIGITS * 4) begin
      step();
      if (last_sel == 4'b0010) chk("segm_3f", segm, 8'h3F);
    end
    wr_valid = 1'b1; wr_addr = 3'd4; wr_data = 8'hFF; step();
    wr_valid = 1'b0; commit = 1'b1; step(); commit = 1'b0;
    wait_tick(); repeat (DIGITS * 4 + 2) step();

    // Mid-slot cfg_div change only affects the next slot.
    cfg_div = 16'd3; cfg_on = 16'd16; wait_tick();
    c0 = 0; n = 0;
    do begin
      step(); n++;
      if (last_sel == 4'b0001) c0++;
      if (c0 == 1) cfg_div = 16'd7;
    end while (last_sel != 4'b0010 && n < 40);
    c1 = 1; n = 0;
    do begin
      step(); n++;
      if (last_sel == 4'b0010) c1++;
    end while (last_sel == 4'b0010 && n < 40);
    chk("slot_keep4", c0, 4);
    chk("slot_next8", c1, 8);

    // Async reset during ON; restart at digit 0 after enable is seen.
    cfg_div = 16'd3; cfg_on = 16'd4;
    n = 0;
    do begin step(); n++; end while (last_sel == '0 && n < 40);
    #2;
    do_reset();
    step(); step();
    chk("restart_digit0", sel, 4'b0001);

    // Enable dropped mid-frame: blank on the next edge, no tick; restart at 0.
    repeat (6) step();
    cfg_en = 1'b0; step();
    chk("drop_sel0", sel, 0);
    step();
    cfg_en = 1'b1; step(); step();
    chk("reen_digit0", sel, 4'b0001);

    // Randomized traffic against the model.
    for (int t = 0; t < 600; t++) begin
      cfg_en   = ($urandom_range(0, 39) != 0);
      wr_valid = $urandom_range(0, 1);
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = SEG_W'($urandom);
      commit   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) cfg_div = DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) cfg_on  = DIV_W'($urandom_range(0, 7));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
